// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor for one restoring-division step.
// borrow=1 means subtrahend > minuend, so the trial result must be discarded.
module div_trial_sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  assign {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider.
// rq holds {remainder, quotient} with one spare top bit; each CALC edge shifts rq left
// and tries to subtract the divisor from the upper half. One quotient bit per edge.
//
// Handshake: run is a level. In IDLE, run=1 loads operands. In CALC, run=1 advances one
// iteration per edge and run=0 pauses with all state held. In DONE, results hold until
// run drops, which returns the FSM to IDLE (results still visible). run must be low for at
// least one edge between operations.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t             state, state_next;
  logic [2*WIDTH:0]   rq, rq_next;
  logic [WIDTH-1:0]   dvsr, dvsr_next;
  logic [CW-1:0]      cnt, cnt_next;
  logic               dbz, dbz_next;

  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     trial_diff;
  logic               trial_borrow;

  // rq[2W] is always 0 entering an iteration, so dropping it in the shift loses nothing.
  assign shifted = {rq[2*WIDTH-1:0], 1'b0};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .minuend   (shifted[2*WIDTH:WIDTH]),
    .subtrahend({1'b0, dvsr}),
    .diff      (trial_diff),
    .borrow    (trial_borrow)
  );

  // Next-state and datapath update selection; everything holds by default.
  always_comb begin
    state_next = state;
    rq_next    = rq;
    dvsr_next  = dvsr;
    cnt_next   = cnt;
    dbz_next   = dbz;
    case (state)
      IDLE: begin
        if (run) begin
          rq_next   = {{(WIDTH + 1){1'b0}}, dividend};
          dvsr_next = divisor;
          cnt_next  = '0;
          if (divisor == '0) begin
            // Divide by zero finishes immediately: quotient all ones, remainder = dividend.
            state_next = DONE;
            dbz_next   = 1'b1;
            rq_next    = {1'b0, dividend, {WIDTH{1'b1}}};
          end else begin
            state_next = CALC;
            dbz_next   = 1'b0;
          end
        end
      end
      CALC: begin
        if (run) begin
          if (trial_borrow) rq_next = shifted;
          else              rq_next = {trial_diff, shifted[WIDTH-1:1], 1'b1};
          cnt_next = cnt + 1'b1;
          if (cnt == LAST_ITER) state_next = DONE;
        end
      end
      DONE: begin
        if (!run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rq    <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
    end else begin
      state <= state_next;
      rq    <= rq_next;
      dvsr  <= dvsr_next;
      cnt   <= cnt_next;
      dbz   <= dbz_next;
    end
  end

  assign quotient    = rq[WIDTH-1:0];
  assign remainder   = rq[2*WIDTH-1:WIDTH];
  assign busy        = (state == CALC);
  assign done        = (state == DONE);
  assign div_by_zero = (state == DONE) && dbz;
  assign fsm_state   = state;

endmodule
